// File: rtl/sbio_bus_arbiter.sv
// Round-robin burst arbiter sharing one bidirectional SB_IO pin group between N_REQ requesters.
// Latency: gnt one edge after req seen in IDLE; pin_oe/pin_dout/rdata/rvalid one edge after each beat.
// Backpressure: the owner paces beats by holding req; waiting requesters stall until a grant reaches them.
// Ports: C/R_N clock and async active-low reset; req/we/wdata per-requester request, direction and write data;
//        gnt one-hot grant; rdata/rvalid shared read data with one-hot strobe;
//        pin_oe/pin_dout/pin_din to/from the SB_IO OUTPUT_ENABLE, D_OUT_0 and D_IN_0.
module sbio_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_BURST  = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                     C,
  input  logic                     R_N,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         rdata,
  output logic [N_REQ-1:0]         rvalid,
  output logic                     pin_oe,
  output logic [WIDTH-1:0]         pin_dout,
  input  logic [WIDTH-1:0]         pin_din
);

  localparam int PW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic             dir_we;
  logic [7:0]       beat_cnt;
  logic [2:0]       turn_cnt;

  logic [PW-1:0]    pick;
  logic             pick_found;
  logic [N_REQ-1:0] pick_onehot;
  int               rr_idx;
  logic [WIDTH-1:0] owner_wdata;
  logic             beat;
  logic             last_beat;
  logic [PW-1:0]    owner_next;

  // Round-robin search: first set req bit at or after ptr, wrapping.
  always_comb begin
    pick        = '0;
    pick_found  = 1'b0;
    rr_idx      = 0;
    pick_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_idx = (int'(ptr) + i) % N_REQ;
      if (!pick_found && req[rr_idx]) begin
        pick_found  = 1'b1;
        pick        = PW'(rr_idx);
      end
    end
    pick_onehot[pick] = 1'b1;
  end

  always_comb begin
    owner_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == owner) begin
        owner_wdata = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign beat       = req[owner];
  // beat_cnt counts beats already taken, so this beat is the MAX_BURST-th one.
  assign last_beat  = beat && (beat_cnt == 8'(MAX_BURST - 1));
  assign owner_next = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      dir_we   <= 1'b0;
      beat_cnt <= '0;
      turn_cnt <= '0;
      gnt      <= '0;
      rdata    <= '0;
      rvalid   <= '0;
      pin_oe   <= 1'b0;
      pin_dout <= '0;
    end else begin
      // rvalid is a single-cycle strobe per read beat.
      rvalid <= '0;
      case (state)
        S_IDLE: begin
          pin_oe <= 1'b0;
          if (pick_found) begin
            owner    <= pick;
            dir_we   <= we[pick];
            beat_cnt <= '0;
            gnt      <= pick_onehot;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (dir_we) begin
              pin_oe   <= 1'b1;
              pin_dout <= owner_wdata;
            end else begin
              pin_oe        <= 1'b0;
              rdata         <= pin_din;
              rvalid[owner] <= 1'b1;
            end
          end else begin
            pin_oe <= 1'b0;
          end
          // A cycle without a beat, or the final allowed beat, closes the burst.
          if (!beat || last_beat) begin
            state    <= S_TURN;
            gnt      <= '0;
            ptr      <= owner_next;
            turn_cnt <= '0;
          end
        end
        S_TURN: begin
          pin_oe <= 1'b0;
          if (turn_cnt == 3'(TURNAROUND - 1)) begin
            state <= S_IDLE;
          end else begin
            turn_cnt <= turn_cnt + 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbio_bus_arbiter.sv
// Self-checking bench for sbio_bus_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations (write, read, contention, max burst,
// async reset mid-burst, direction lock).
module tb_sbio_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int TA = 1;

  logic           C = 1'b0;
  logic           R_N = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   we = '0;
  logic [N*W-1:0] wdata = '0;
  logic [W-1:0]   pin_din = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   rdata;
  logic [N-1:0]   rvalid;
  logic           pin_oe;
  logic [W-1:0]   pin_dout;

  int n_chk = 0;
  int n_fail = 0;

  sbio_bus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB), .TURNAROUND(TA)) dut (
    .C(C), .R_N(R_N), .req(req), .we(we), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .pin_oe(pin_oe), .pin_dout(pin_dout), .pin_din(pin_din)
  );

  always #5 C = ~C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The bus is either owned (m_owner >= 0) or free; a freed bus must cool
  // down for TA cycles before the next arbitration cycle may grant it.
  int           m_owner = -1;
  int           m_dir = 0;
  int           m_beats = 0;
  int           m_cool = 0;
  int           m_ptr = 0;
  logic [N-1:0] e_gnt = '0;
  logic [N-1:0] e_rvalid = '0;
  logic [W-1:0] e_rdata = '0;
  logic [W-1:0] e_dout = '0;
  logic         e_oe = 1'b0;

  task automatic release_bus();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_cool  = TA;
    e_gnt   = '0;
  endtask

  always @(posedge C or negedge R_N) begin : model
    if (!R_N) begin
      m_owner = -1; m_dir = 0; m_beats = 0; m_cool = 0; m_ptr = 0;
      e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_dout = '0; e_oe = 1'b0;
    end else begin
      e_rvalid = '0;
      if (m_owner >= 0) begin
        if (req[m_owner]) begin
          m_beats++;
          if (m_dir != 0) begin
            e_oe   = 1'b1;
            e_dout = wdata[m_owner*W +: W];
          end else begin
            e_oe     = 1'b0;
            e_rdata  = pin_din;
            e_rvalid[m_owner] = 1'b1;
          end
          if (m_beats == MB) release_bus();
        end else begin
          e_oe = 1'b0;
          release_bus();
        end
      end else if (m_cool > 0) begin
        m_cool--;
        e_oe = 1'b0;
      end else begin
        e_oe = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_owner < 0 && req[c]) begin
            m_owner  = c;
            m_dir    = int'(we[c]);
            m_beats  = 0;
            e_gnt    = '0;
            e_gnt[c] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge C) begin : compare
    chk("gnt", gnt, e_gnt);
    chk("rvalid", rvalid, e_rvalid);
    chk("pin_oe", pin_oe, e_oe);
    if (e_rvalid != '0) chk("rdata", rdata, e_rdata);
    if (e_oe) chk("pin_dout", pin_dout, e_dout);
  end

  task automatic cyc();
    @(posedge C);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  logic [N-1:0] grants[$];
  int           gaps[$];
  logic [N-1:0] exp_order[5];
  logic [N-1:0] prev_gnt;
  int           zero_run;
  int           oe_first;

  initial begin
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (2) @(posedge C);
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_oe", pin_oe, 0);
    chk("rst_dout", pin_dout, 0);
    R_N = 1'b1;

    // Single write burst A0, A1, A2 from requester 2.
    req = 4'b0100; we = 4'b0100; wdata[2*W +: W] = 8'hA0;
    cyc(); chk("t1_gnt", gnt, 4'b0100); chk("t1_oe0", pin_oe, 0);
    cyc(); chk("t1_oe_a0", pin_oe, 1); chk("t1_a0", pin_dout, 8'hA0); wdata[2*W +: W] = 8'hA1;
    cyc(); chk("t1_oe_a1", pin_oe, 1); chk("t1_a1", pin_dout, 8'hA1); wdata[2*W +: W] = 8'hA2;
    cyc(); chk("t1_oe_a2", pin_oe, 1); chk("t1_a2", pin_dout, 8'hA2); req = '0;
    cyc(); chk("t1_end_oe", pin_oe, 0); chk("t1_end_gnt", gnt, 0);
    cyc(); chk("t1_idle_oe", pin_oe, 0);
    we = '0;

    // Read burst from requester 1: 55 then 66.
    req = 4'b0010; pin_din = 8'h55;
    cyc(); chk("t2_gnt", gnt, 4'b0010); chk("t2_rv0", rvalid, 0);
    cyc(); chk("t2_rv1", rvalid, 4'b0010); chk("t2_rd55", rdata, 8'h55); chk("t2_oe", pin_oe, 0); pin_din = 8'h66;
    cyc(); chk("t2_rv2", rvalid, 4'b0010); chk("t2_rd66", rdata, 8'h66); req = '0;
    cyc(); chk("t2_rv_end", rvalid, 0); chk("t2_oe_end", pin_oe, 0);
    repeat (3) cyc();

    // Contention from a fresh pointer; bursts are capped at MB beats.
    R_N = 1'b0;
    cyc();
    R_N = 1'b1;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'(8'h10 + i);
    req = 4'b1111; we = 4'b1111;
    prev_gnt = '0; zero_run = 0; oe_first = 0;
    for (int cnt = 0; cnt < 200 && grants.size() < 5; cnt++) begin
      cyc();
      if (gnt != '0 && prev_gnt == '0) begin
        grants.push_back(gnt);
        if (grants.size() > 1) gaps.push_back(zero_run);
        zero_run = 0;
      end
      if (gnt == '0) zero_run++;
      if (grants.size() == 1 && pin_oe) oe_first++;
      prev_gnt = gnt;
    end
    chk("t3_ngrants", grants.size(), 5);
    for (int i = 0; i < grants.size(); i++) chk("t3_order", grants[i], exp_order[i]);
    foreach (gaps[i]) chk("t3_gap_ge_ta", (gaps[i] >= TA) ? 1 : 0, 1);
    chk("t4_maxburst_beats", oe_first, MB);
    req = '0;
    repeat (8) cyc();

    // Async reset during the second beat of a write.
    req = 4'b0001; we = 4'b0001; wdata[0 +: W] = 8'h11;
    cyc(); chk("t5_gnt", gnt, 4'b0001);
    cyc(); chk("t5_oe", pin_oe, 1); chk("t5_b1", pin_dout, 8'h11); wdata[0 +: W] = 8'h22;
    #1 R_N = 1'b0;
    #1;
    chk("t5_rst_oe", pin_oe, 0); chk("t5_rst_gnt", gnt, 0); chk("t5_rst_rv", rvalid, 0);
    cyc();
    R_N = 1'b1; req = 4'b0010; we = '0; pin_din = 8'h77;
    cyc(); chk("t5_regnt", gnt, 4'b0010);
    cyc(); chk("t5_rv", rvalid, 4'b0010); chk("t5_rd", rdata, 8'h77); req = '0;
    repeat (4) cyc();

    // Direction lock: we drops after the first write beat.
    req = 4'b1000; we = 4'b1000; wdata[3*W +: W] = 8'h3C;
    cyc(); chk("t6_gnt", gnt, 4'b1000);
    cyc(); chk("t6_oe1", pin_oe, 1); chk("t6_d1", pin_dout, 8'h3C); chk("t6_rv1", rvalid, 0);
    we = '0; wdata[3*W +: W] = 8'h3D;
    cyc(); chk("t6_oe2", pin_oe, 1); chk("t6_d2", pin_dout, 8'h3D); chk("t6_rv2", rvalid, 0);
    cyc(); chk("t6_oe3", pin_oe, 1); chk("t6_rv3", rvalid, 0); req = '0;
    cyc(); chk("t6_end_oe", pin_oe, 0); chk("t6_end_gnt", gnt, 0);
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sbio_bus_arbiter.md
# sbio_bus_arbiter

Round-robin arbiter that shares one bidirectional SB_IO pin group (PACKAGE_PIN bus, OUTPUT_ENABLE, D_OUT_0, D_IN_0) between N_REQ requesters. It grants the bus in bursts, drives the SB_IO output enable and data, captures read data, and inserts a guaranteed turnaround gap between owners so no two drivers ever overlap. It sits between the requester logic and a row of SB_IO cells configured with registered output, registered OE and plain input.

## Interface
- N_REQ, 4: number of requesters (2..8).
- WIDTH, 8: pin bus width.
- MAX_BURST, 16: maximum beats per grant (1..255).
- TURNAROUND, 1: idle cycles with OE low after every burst (1..7).

- C  in  1  clock, rising edge.
- R_N  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester bus request; also qualifies each beat while granted.
- we  in  N_REQ  per-requester direction, 1 = write; sampled only at grant.
- wdata  in  N_REQ*WIDTH  per-requester write data, requester i at bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant, registered.
- rdata  out  WIDTH  read data, shared by all requesters, registered.
- rvalid  out  N_REQ  one-hot read-beat strobe, registered.
- pin_oe  out  1  to SB_IO OUTPUT_ENABLE, registered.
- pin_dout  out  WIDTH  to SB_IO D_OUT_0, registered.
- pin_din  in  WIDTH  from SB_IO D_IN_0.

## Operation
- States: IDLE, XFER, TURN.
- IDLE: if any req bit is set, select owner by round-robin starting at pointer ptr; latch owner index and we[owner]; clear beat counter; go XFER; gnt[owner] is set on that same edge. If no req, stay.
- XFER: a beat occurs each cycle req[owner]=1. Write beat: pin_dout <= wdata[owner], pin_oe <= 1. Read beat: pin_oe <= 0, rdata <= pin_din, rvalid[owner] <= 1. Beat counter increments per beat.
- Burst ends on the edge where req[owner]=0 (no beat that cycle) or where the MAX_BURST-th beat is taken; go TURN, gnt <= 0, ptr <= owner+1 mod N_REQ.
- TURN: pin_oe <= 0, turnaround counter runs TURNAROUND cycles, then go IDLE.
- Round-robin: search order ptr, ptr+1, ..., wrapping; owner = first set req bit.
- we changes during XFER are ignored; the direction is fixed for the whole burst.
- pin_dout holds its last value when it is not written; it is don't-care while pin_oe=0.
- Reset (R_N low, any time, including mid-burst): state IDLE, gnt=0, rvalid=0, rdata=0, pin_oe=0, pin_dout=0, ptr=0, counters=0, all applied immediately. Any partial burst is dropped without notice.

## Timing
- req rising in an IDLE cycle gives gnt high on the next edge (1 cycle of latency).
- First beat is possible in the first cycle gnt is high.
- Write beat in cycle k: pin_oe and pin_dout are valid from edge k+1.
- Read beat in cycle k: pin_din is sampled at edge k+1; rdata and rvalid are valid for cycle k+1 only, so rvalid is a 1-cycle pulse per beat.
- The last write beat in cycle k gives pin_oe=1 during cycle k+1 and pin_oe=0 from edge k+2. TURN occupies TURNAROUND cycles from edge k+1. The next gnt is no earlier than 2+TURNAROUND cycles after the last beat.
- Minimum bus-idle gap between owners: TURNAROUND cycles with pin_oe=0 before any new write data is driven.
- A request from a non-owner that arrives during XFER or TURN waits; it is not lost as long as req stays high.

## Test plan
- Single write, N_REQ=4, TURNAROUND=1: req[2]=1, we[2]=1, wdata values A0,A1,A2 then req drops -> gnt=0100 on the next edge; pin_oe=1 for 3 cycles carrying A0,A1,A2; pin_oe=0 after; IDLE 2 cycles after the last beat.
- Read burst: req[1], we[1]=0, pin_din=55,66 on successive beats -> rvalid=0010 pulses twice with rdata=55 then 66, 1 cycle after each beat; pin_oe stays 0.
- Contention: req=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001; each is separated by ≥TURNAROUND cycles with pin_oe=0 and gnt=0.
- MAX_BURST=4, req[0] held with a write -> exactly 4 beats, then a forced TURN; if req[0] is still high, requester 0 is regranted only after the other pending requesters.
- Reset mid-burst: R_N low during beat 2 of a write -> pin_oe, gnt and rvalid go to 0 at once without waiting for C; after release with req=0010, requester 1 is granted (ptr=0 search).
- Direction lock: we toggled 1->0 mid-burst -> pin_oe stays 1 and no rvalid pulse occurs until the burst ends.
